// File: rtl/bus_region_ctrl.sv
// bus_region_ctrl: 68040 bus-cycle controller; latches A on TS, decodes NREG regions, issues TA/TEA.
// Optional bus-timeout watchdog is compiled in with `define BUS_TIMEOUT_EN.
module bus_region_ctrl #(
    parameter int                          NREG      = 4,
    parameter int                          DEC_BITS  = 4,
    parameter logic [NREG*DEC_BITS-1:0]    REG_BASE  = 16'h6420,
    parameter logic [NREG*4-1:0]           REG_WS    = 16'h0010,
    parameter logic [NREG-1:0]             REG_EXT   = 4'b1010,
    parameter int                          TO_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ts_n,
    input  logic [31:0]     a,
    input  logic            rw,
    input  logic [NREG-1:0] ext_ack,
    output logic [NREG-1:0] sel,
    output logic            stb,
    output logic [31:0]     addr_q,
    output logic            rw_q,
    output logic            ta_n,
    output logic            tea_n,
    output logic            d_oe_n,
    output logic            busy
);
    localparam int RW  = NREG > 1 ? $clog2(NREG) : 1;
    localparam int TCW = $clog2(TO_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, DECODE, WAIT, ACK, ERR} state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   reg_q, reg_d, hit_idx;
    logic            hit_any;
    logic [3:0]      wcnt_q, wcnt_d;
    logic [NREG-1:0] sel_q, sel_d;
    logic            stb_q, stb_d, ta_n_q, ta_n_d, tea_n_q, tea_n_d;
    logic            d_oe_n_q, d_oe_n_d, busy_q, busy_d, rw_d;
    logic [31:0]     addr_d;
    logic            ext_done, int_done, timeout;

`ifdef BUS_TIMEOUT_EN
    logic [TCW-1:0]  tcnt_q, tcnt_d;
    assign timeout = tcnt_q == TCW'(TO_CYCLES - 1);
    assign tcnt_d  = (state_q == DECODE) ? '0 :
                     (state_q == WAIT && tcnt_q != {TCW{1'b1}}) ? tcnt_q + 1'b1 : tcnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) tcnt_q <= '0;
        else     tcnt_q <= tcnt_d;
`else
    assign timeout = 1'b0;
`endif

    // Lowest-numbered matching region wins, so scan downward and let later hits overwrite.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NREG - 1; i >= 0; i--)
            if (addr_q[31 -: DEC_BITS] == REG_BASE[i*DEC_BITS +: DEC_BITS]) begin
                hit_any = 1'b1;
                hit_idx = RW'(i);
            end
    end

    assign ext_done = REG_EXT[reg_q] && ext_ack[reg_q];
    assign int_done = !REG_EXT[reg_q] && wcnt_q == 4'd0;

    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ts_n ? IDLE : DECODE;
            DECODE:  state_d = &addr_q ? ACK : hit_any ? WAIT : ERR;
            WAIT:    state_d = (ext_done || int_done) ? ACK : timeout ? ERR : WAIT;
            default: state_d = IDLE;
        endcase
    end

    // ACK and ERR always last one cycle, so state_d==ACK/ERR means "entering" it.
    always_comb begin
        addr_d   = (state_q == IDLE && !ts_n) ? a : addr_q;
        rw_d     = (state_q == IDLE && !ts_n) ? rw : rw_q;
        reg_d    = (state_q == DECODE) ? hit_idx : reg_q;
        wcnt_d   = (state_q == DECODE) ? REG_WS[hit_idx*4 +: 4] :
                   (state_q == WAIT && wcnt_q != 4'd0) ? wcnt_q - 4'd1 : wcnt_q;
        sel_d    = (state_d == ACK || state_d == ERR) ? '0 :
                   (state_d == WAIT && state_q == DECODE) ? NREG'(1) << hit_idx : sel_q;
        stb_d    = |sel_d;
        ta_n_d   = state_d != ACK;
        tea_n_d  = state_d != ERR;
        d_oe_n_d = !(state_d == ACK && rw_q);
        busy_d   = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            addr_q   <= '0;
            rw_q     <= 1'b0;
            reg_q    <= '0;
            wcnt_q   <= '0;
            sel_q    <= '0;
            stb_q    <= 1'b0;
            ta_n_q   <= 1'b1;
            tea_n_q  <= 1'b1;
            d_oe_n_q <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            reg_q    <= reg_d;
            wcnt_q   <= wcnt_d;
            sel_q    <= sel_d;
            stb_q    <= stb_d;
            ta_n_q   <= ta_n_d;
            tea_n_q  <= tea_n_d;
            d_oe_n_q <= d_oe_n_d;
            busy_q   <= busy_d;
        end

    assign sel    = sel_q;
    assign stb    = stb_q;
    assign ta_n   = ta_n_q;
    assign tea_n  = tea_n_q;
    assign d_oe_n = d_oe_n_q;
    assign busy   = busy_q;
endmodule

// File: tb/tb_bus_region_ctrl.sv
// tb_bus_region_ctrl: two instances (default WS, region 0 WS=3) checked against a transfer-timeline model.
module tb_bus_region_ctrl;
    localparam int BASE = 'h6420;
    localparam int EXT  = 'b1010;
    localparam int WS0  = 'h0010;
    localparam int WS1  = 'h0013;
    localparam int TO   = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ts_n = 1'b1;
    logic [31:0] a = '0;
    logic rw = 1'b0;
    logic [3:0] ext_ack = '0;
    logic [1:0][3:0] o_sel;
    logic [1:0][31:0] o_addr;
    logic [1:0] o_stb, o_rwq, o_ta, o_tea, o_doe, o_busy;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    bus_region_ctrl dut0 (
        .clk(clk), .rst(rst), .ts_n(ts_n), .a(a), .rw(rw), .ext_ack(ext_ack),
        .sel(o_sel[0]), .stb(o_stb[0]), .addr_q(o_addr[0]), .rw_q(o_rwq[0]),
        .ta_n(o_ta[0]), .tea_n(o_tea[0]), .d_oe_n(o_doe[0]), .busy(o_busy[0]));

    bus_region_ctrl #(.REG_WS(16'h0013)) dut1 (
        .clk(clk), .rst(rst), .ts_n(ts_n), .a(a), .rw(rw), .ext_ack(ext_ack),
        .sel(o_sel[1]), .stb(o_stb[1]), .addr_q(o_addr[1]), .rw_q(o_rwq[1]),
        .ta_n(o_ta[1]), .tea_n(o_tea[1]), .d_oe_n(o_doe[1]), .busy(o_busy[1]));

    function automatic int region(logic [31:0] ad);
        for (int i = 0; i < 4; i++)
            if (int'(ad[31:28]) == ((BASE >> (i * 4)) & 15)) return i;
        return -1;
    endfunction

    function automatic int ws_of(int k, int r);
        return (((k == 0) ? WS0 : WS1) >> (r * 4)) & 15;
    endfunction

    // Model: each transfer is a start edge n0, a region, and a completion edge (ack or error).
    bit          m_act [2];
    bit          m_err [2];
    int          m_n0  [2];
    int          m_end [2];
    int          m_reg [2];
    logic [31:0] m_addr[2];
    logic        m_rw  [2];
    logic [3:0]  e_sel [2];
    logic        e_ta[2], e_tea[2], e_doe[2], e_busy[2];

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_act[k] = 0; m_addr[k] = '0; m_rw[k] = 0; m_end[k] = -1; m_reg[k] = -1;
            end else begin
                if (m_act[k] && m_end[k] >= 0 && cyc >= m_end[k] + 2) m_act[k] = 0;
                if (!m_act[k]) begin
                    if (!ts_n) begin
                        m_act[k] = 1; m_n0[k] = cyc; m_end[k] = -1; m_reg[k] = -1;
                        m_addr[k] = a; m_rw[k] = rw;
                    end
                end else if (m_end[k] < 0) begin
                    if (cyc == m_n0[k] + 1) begin
                        if (m_addr[k] == 32'hFFFF_FFFF) begin
                            m_end[k] = cyc; m_err[k] = 0;
                        end else begin
                            m_reg[k] = region(m_addr[k]);
                            if (m_reg[k] < 0) begin
                                m_end[k] = cyc; m_err[k] = 1;
                            end else if (((EXT >> m_reg[k]) & 1) == 0) begin
                                m_end[k] = m_n0[k] + 2 + ws_of(k, m_reg[k]); m_err[k] = 0;
                            end
                        end
                    end else if (ext_ack[m_reg[k]]) begin
                        m_end[k] = cyc; m_err[k] = 0;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (cyc == m_n0[k] + 1 + TO) begin
                        m_end[k] = cyc; m_err[k] = 1;
                    end
`endif
                end
            end
            e_busy[k] = m_act[k] && !(m_end[k] >= 0 && cyc >= m_end[k] + 1);
            e_sel[k]  = (m_act[k] && m_reg[k] >= 0 && cyc >= m_n0[k] + 1 && (m_end[k] < 0 || cyc < m_end[k]))
                        ? 4'(1 << m_reg[k]) : 4'd0;
            e_ta[k]   = !(m_act[k] && cyc == m_end[k] && !m_err[k]);
            e_tea[k]  = !(m_act[k] && cyc == m_end[k] && m_err[k]);
            e_doe[k]  = !(m_act[k] && cyc == m_end[k] && !m_err[k] && m_rw[k]);
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [41:0] act, req;
            act = {o_sel[k], o_stb[k], o_addr[k], o_rwq[k], o_ta[k], o_tea[k], o_doe[k], o_busy[k]};
            req = rst ? {4'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}
                      : {e_sel[k], |e_sel[k], m_addr[k], m_rw[k], e_ta[k], e_tea[k], e_doe[k], e_busy[k]};
            n_cmp++;
            if (act !== req) begin
                n_bad++;
                $display("FAIL cycle%0d dut%0d {sel,stb,addr,rw,ta,tea,doe,busy}: got %h want %h", cyc, k, act, req);
            end
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic go(logic [31:0] ad, logic r);
        ts_n = 1'b0; a = ad; rw = r;
        tick();
        ts_n = 1'b1;
    endtask

    initial begin
        tick(3);
        chk("rst_ta", 32'(o_ta[0]), 1);
        chk("rst_busy", 32'(o_busy[0]), 0);
        rst = 1'b0;
        tick(2);
        // read region 0, no wait states
        go(32'h0000_1000, 1'b1);
        chk("r0_busy", 32'(o_busy[0]), 1);
        tick();
        chk("r0_sel", 32'(o_sel[0]), 1);
        chk("r0_ta_early", 32'(o_ta[0]), 1);
        tick();
        chk("r0_ta", 32'(o_ta[0]), 0);
        chk("r0_doe", 32'(o_doe[0]), 0);
        tick();
        chk("r0_ta_rel", 32'(o_ta[0]), 1);
        chk("r0_idle", 32'(o_busy[0]), 0);
        tick(6);
        // write external region 1, slave acks at edge N+6
        go(32'h2000_0004, 1'b0);
        tick(5);
        chk("r1_sel", 32'(o_sel[0]), 2);
        chk("r1_ta_wait", 32'(o_ta[0]), 1);
        ext_ack = 4'b0010;
        tick();
        ext_ack = 4'b0000;
        chk("r1_ta", 32'(o_ta[0]), 0);
        chk("r1_doe", 32'(o_doe[0]), 1);
        tick(4);
        // region 0 with three wait states (second instance)
        go(32'h0000_0000, 1'b1);
        tick(4);
        chk("ws3_sel", 32'(o_sel[1]), 1);
        chk("ws3_ta_wait", 32'(o_ta[1]), 1);
        tick();
        chk("ws3_ta", 32'(o_ta[1]), 0);
        chk("ws3_sel_off", 32'(o_sel[1]), 0);
        tick();
        chk("ws3_ta_rel", 32'(o_ta[1]), 1);
        tick(3);
        // unmapped
        go(32'hA000_0000, 1'b1);
        tick();
        chk("err_tea", 32'(o_tea[0]), 0);
        chk("err_ta", 32'(o_ta[0]), 1);
        chk("err_sel", 32'(o_sel[0]), 0);
        tick();
        chk("err_tea_rel", 32'(o_tea[0]), 1);
        tick(3);
        // autovector then back-to-back TS in the IDLE cycle after ACK
        go(32'hFFFF_FFFF, 1'b1);
        tick();
        chk("vec_ta", 32'(o_ta[0]), 0);
        chk("vec_sel", 32'(o_sel[0]), 0);
        tick();
        go(32'h4000_0000, 1'b0);
        chk("b2b_busy", 32'(o_busy[0]), 1);
        chk("b2b_addr", o_addr[0], 32'h4000_0000);
        tick();
        chk("b2b_sel", 32'(o_sel[0]), 4);
        tick();
        chk("b2b_ta", 32'(o_ta[0]), 0);
        chk("b2b_doe", 32'(o_doe[0]), 1);
        tick(3);
        // external region 3 never acknowledges; a stray TS while busy is ignored
        go(32'h6000_0000, 1'b1);
        tick(3);
        ts_n = 1'b0; a = 32'h0000_0000;
        tick();
        ts_n = 1'b1;
        chk("hang_addr", o_addr[0], 32'h6000_0000);
`ifdef BUS_TIMEOUT_EN
        tick(60);
        chk("to_tea_early", 32'(o_tea[0]), 1);
        tick();
        chk("to_tea", 32'(o_tea[0]), 0);
        tick();
`else
        repeat (200) begin
            tick();
            chk("hang_busy", 32'(o_busy[0]), 1);
        end
`endif
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(o_busy[0]), 0);
        chk("arst_addr", o_addr[0], 0);
        chk("arst_ta", 32'(o_ta[0]), 1);
        tick(2);
        rst = 1'b0;
        tick();
        go(32'h0000_1000, 1'b1);
        tick(2);
        chk("post_rst_ta", 32'(o_ta[0]), 0);
        tick(6);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
